sram_access_controller: RTL

- Multi-cycle controller between the EX/MEM pipeline boundary and the off-chip 16-bit asynchronous SRAM.
- Takes the memory read/write enables and the ALU-computed address from the stage register, splits each 32-bit word access into two 16-bit SRAM transactions, and inserts programmable wait cycles.
- Drives ready low so the hazard/freeze logic stalls all earlier stages until the access completes.

---
 rtl/sram_ctrl_defs_pkg.sv | 20 ++
 rtl/sram_wait_counter.sv | 28 ++
 rtl/sram_access_controller.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_defs_pkg.sv
// Shared definitions for the SRAM access controller: state encoding,
// default data-memory base, SRAM address width and bus widths.
package sram_ctrl_defs;

    localparam int unsigned WORD_W          = 32;
    localparam int unsigned HALF_W          = 16;
    localparam int unsigned SRAM_AW_DEFAULT = 18;
    localparam int unsigned CNT_W           = 4;

    localparam logic [WORD_W-1:0] BASE_ADDR_DEFAULT = 32'd1024;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOW  = 3'd1,
        ST_HIGH = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/sram_wait_counter.sv
// Wait-state counter: load clears, enable increments, tc flags count==limit.
module sram_wait_counter
    import sram_ctrl_defs::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             tc
);

    logic [CNT_W-1:0] count;

    // Count register, cleared on load, advanced on enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign tc = (count == limit);

endmodule

// File: rtl/sram_access_controller.sv
// Multi-cycle controller between the EX/MEM boundary and a 16-bit async SRAM.
// Each 32-bit word access becomes a low-half then a high-half SRAM cycle,
// followed by WAIT_CYCLES idle cycles; ready stays low until completion.
// Optional macro SRAM_CTRL_LAST_READ_CACHE_EN adds a one-entry last-read cache.
module sram_access_controller
    import sram_ctrl_defs::*;
#(
    parameter logic [WORD_W-1:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
    parameter int unsigned       WAIT_CYCLES = 2,
    parameter int unsigned       SRAM_AW     = SRAM_AW_DEFAULT
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                RD_EN,
    input  logic                WR_EN,
    input  logic [WORD_W-1:0]   address,
    input  logic [WORD_W-1:0]   writeData,
    output logic [WORD_W-1:0]   readData,
    output logic                ready,
    inout  wire  [HALF_W-1:0]   SRAM_DQ,
    output logic [SRAM_AW-1:0]  SRAM_ADDR,
    output logic                SRAM_WE_N,
    output logic                SRAM_OE_N,
    output logic                SRAM_CE_N,
    output logic                SRAM_UB_N,
    output logic                SRAM_LB_N
);

    localparam int unsigned      IDX_W      = SRAM_AW - 1;
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(WAIT_CYCLES - 1);

    state_t              state;
    logic                op_wr;
    logic [IDX_W-1:0]    idx;
    logic [WORD_W-1:0]   data;
    logic                dq_oe;
    logic                req;
    logic [IDX_W-1:0]    req_idx;
    logic                wait_tc;

`ifdef SRAM_CTRL_LAST_READ_CACHE_EN
    logic                cache_valid;
    logic [IDX_W-1:0]    cache_idx;
    logic [WORD_W-1:0]   cache_word;
    logic                cache_hit;
`endif

    assign req     = RD_EN | WR_EN;
    // Word index after rebasing; byte-offset bits and bits above the SRAM drop out.
    assign req_idx = IDX_W'((address - BASE_ADDR) >> 2);

    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

    // Drive the data bus only while writing a half-word.
    assign SRAM_DQ = dq_oe ? ((state == ST_HIGH) ? data[WORD_W-1:HALF_W] : data[HALF_W-1:0])
                           : {HALF_W{1'bz}};

`ifdef SRAM_CTRL_LAST_READ_CACHE_EN
    assign cache_hit = RD_EN & ~WR_EN & cache_valid & (cache_idx == req_idx);
`endif

    // Ready: combinational request check in IDLE, one-cycle pulse in DONE.
    always_comb begin
        ready = 1'b0;
        if (state == ST_IDLE) begin
            ready = ~req;
        end else if (state == ST_DONE) begin
            ready = 1'b1;
        end
    end

    sram_wait_counter u_wait_counter (
        .clk   (CLK),
        .rst   (RST),
        .load  (state == ST_HIGH),
        .en    (state == ST_WAIT),
        .limit (WAIT_LIMIT),
        .tc    (wait_tc)
    );

    // Access sequencer with registered SRAM strobes and read capture.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            op_wr     <= 1'b0;
            idx       <= '0;
            data      <= '0;
            readData  <= '0;
            SRAM_ADDR <= '0;
            SRAM_WE_N <= 1'b1;
            SRAM_OE_N <= 1'b0;
            dq_oe     <= 1'b0;
`ifdef SRAM_CTRL_LAST_READ_CACHE_EN
            cache_valid <= 1'b0;
            cache_idx   <= '0;
            cache_word  <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        op_wr <= WR_EN;
                        idx   <= req_idx;
                        data  <= writeData;
`ifdef SRAM_CTRL_LAST_READ_CACHE_EN
                        if (cache_hit) begin
                            readData <= cache_word;
                            state    <= ST_DONE;
                        end else
`endif
                        begin
                            state     <= ST_LOW;
                            SRAM_ADDR <= {req_idx, 1'b0};
                            SRAM_WE_N <= ~WR_EN;
                            SRAM_OE_N <= WR_EN;
                            dq_oe     <= WR_EN;
                        end
                    end
                end
                ST_LOW: begin
                    if (!op_wr) begin
                        readData[HALF_W-1:0] <= SRAM_DQ;
                    end
                    SRAM_ADDR <= {idx, 1'b1};
                    state     <= ST_HIGH;
                end
                ST_HIGH: begin
                    if (!op_wr) begin
                        readData[WORD_W-1:HALF_W] <= SRAM_DQ;
                    end
`ifdef SRAM_CTRL_LAST_READ_CACHE_EN
                    if (!op_wr) begin
                        cache_valid <= 1'b1;
                        cache_idx   <= idx;
                        cache_word  <= {SRAM_DQ, readData[HALF_W-1:0]};
                    end else if (cache_valid && (cache_idx == idx)) begin
                        cache_word  <= data;
                    end
`endif
                    SRAM_ADDR <= '0;
                    SRAM_WE_N <= 1'b1;
                    SRAM_OE_N <= 1'b0;
                    dq_oe     <= 1'b0;
                    state     <= (WAIT_CYCLES == 0) ? ST_DONE : ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_tc) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
